vec_requant_buffer: RTL and testbench
=====================================

# vec_requant_buffer

Output stage directly downstream of `reduction_accumulator`. It takes each 4-lane 32-bit accumulator vector and requantizes every lane to signed int8 using scale, rounding shift, optional ReLU, zero-point and saturation. It packs the lanes into one word and buffers the words in a FIFO. That FIFO gives a ready/valid interface towards the writeback/SRAM path. Upstream has no backpressure, so the block never stalls its input and flags any loss.

## Interface
- `TILE_SIZE`, 4: lanes per vector.
- `ACC_WIDTH`, 32: signed input lane width.
- `OUT_WIDTH`, 8: signed output lane width.
- `SCALE_WIDTH`, 16: signed scale multiplier width.
- `SHIFT_WIDTH`, 5: right-shift amount width (0..31).
- `FIFO_DEPTH`, 8: output FIFO entries; power of two, ≥2.
- `clk` input 1: clock; all logic on the rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `valid_in` input 1: `vec_in` is valid this cycle; accepted unconditionally.
- `vec_in` input [TILE_SIZE][ACC_WIDTH] signed: accumulator vector (connects to `vec_out`).
- `cfg_scale` input SCALE_WIDTH signed: multiplier.
- `cfg_shift` input SHIFT_WIDTH unsigned: rounding right-shift.
- `cfg_zero_point` input OUT_WIDTH signed: output offset.
- `cfg_relu_en` input 1: clamp negative scaled values to 0.
- `out_valid` output 1: FIFO non-empty.
- `out_ready` input 1: consumer accepts `out_data`.
- `out_data` output TILE_SIZE*OUT_WIDTH: packed lanes; lane k in bits [k*OUT_WIDTH +: OUT_WIDTH].
- `fifo_count` output $clog2(FIFO_DEPTH+1): occupied entries.
- `overflow` output 1: sticky; a vector was dropped.
- `clr_overflow` input 1: clears `overflow`.

## Operation
- All `cfg_*` inputs are sampled together with `vec_in` on the valid edge and carried down the pipeline. Changing config mid-stream affects only vectors sampled afterwards.
- Stage 1 (S1): per lane, p = vec_in[k] * cfg_scale. p is signed, ACC_WIDTH+SCALE_WIDTH bits.
- Stage 2 (S2): per lane, in ACC_WIDTH+SCALE_WIDTH+1 bits:
  - r = (p + (shift>0 ? 1<<(shift-1) : 0)) >>> shift. This is round-half-up toward +inf, arithmetic shift.
  - If relu_en and r<0, then r=0.
  - q = r + sign-extended zero_point.
  - Saturate q to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Pack lanes, then push into the FIFO.
- FIFO:
  - Push when S2 is valid.
  - Pop when out_valid && out_ready.
  - out_data shows the head entry. It is forced to 0 when empty.
  - Order is strictly first-in first-out.
- Full FIFO:
  - Push with no pop: the word is dropped, `overflow` is set, count stays FIFO_DEPTH.
  - Push with a simultaneous pop: the push is accepted, no overflow, count unchanged.
- Empty FIFO: there is no bypass. A word becomes visible the cycle after it is written. Simultaneous push and pop cannot occur when empty.
- `overflow`: set on a drop, cleared by `clr_overflow`. If a drop and `clr_overflow` happen in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (synchronous, high at a rising edge):
  - S1/S2 valids cleared; in-flight vectors are discarded.
  - FIFO pointers 0.
  - out_valid=0, out_data=0, fifo_count=0, overflow=0.
  - valid_in is ignored while rst=1.
- Latency:
  - valid_in sampled at edge E0 → S1 registered at E0 → S2 registered at E1 → FIFO write at E2.
  - out_valid=1 in the cycle after E2 if the FIFO was empty, i.e. 3 cycles after the input cycle.
- Throughput: one vector per cycle sustained, as long as out_ready=1.
- fifo_count updates on the same edge as the push/pop: +1 on push only, -1 on pop only, unchanged on both.
- out_valid, out_data and fifo_count are registered or derived from registered state only. There is no combinational path from out_ready to out_valid.

## Test plan
- Pass-through:
  - Stimulus: scale=1, shift=0, zp=0, relu=0, vec_in=[5,-3,127,-128].
  - Response: out_data=0x807FFD05, out_valid rising exactly 3 cycles after the valid_in cycle.
- Rounding:
  - Stimulus: scale=3, shift=2, vec_in=[1,2,-2,-1].
  - Response: lanes [1,2,-1,-1] → out_data=0xFFFF0201.
- ReLU, zero-point and saturation:
  - Stimulus: scale=1, shift=0, zp=10, relu=1, vec_in=[200,-50,100,0].
  - Response: lanes [127,10,110,10] → out_data=0x0A6E0A7F.
- Overflow:
  - Stimulus: out_ready=0, 9 back-to-back vectors with lane0 = 1..9.
  - Response: fifo_count=8; overflow=1 after the 9th write edge. With out_ready=1, lane0 drains 1..8 in order, then out_valid=0. Pulsing clr_overflow returns overflow to 0.
- Full with simultaneous pop:
  - Stimulus: FIFO full, out_ready=1 on the cycle a new word arrives.
  - Response: the word is accepted, overflow stays 0, fifo_count stays 8.
- Reset mid-operation:
  - Stimulus: rst asserted 1 cycle after valid_in, with 3 entries queued.
  - Response: next cycle out_valid=0, fifo_count=0, out_data=0. The in-flight vector never appears.

Source files
------------

// File: rtl/vec_requant_buffer.sv
// Requantizes 4-lane accumulator vectors to int8 through a 2-stage pipeline, then packs and queues them in a FIFO.
// Latency is input edge to FIFO write in 2 more edges; the input never stalls, and a word arriving at a full FIFO with no pop is dropped and flagged.
module vec_requant_buffer #(
  parameter int TILE_SIZE   = 4,
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int SCALE_WIDTH = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       valid_in,
  input  logic signed [TILE_SIZE-1:0][ACC_WIDTH-1:0] vec_in,
  input  logic signed [SCALE_WIDTH-1:0]              cfg_scale,
  input  logic        [SHIFT_WIDTH-1:0]              cfg_shift,
  input  logic signed [OUT_WIDTH-1:0]                cfg_zero_point,
  input  logic                                       cfg_relu_en,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic        [TILE_SIZE*OUT_WIDTH-1:0]      out_data,
  output logic        [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
  output logic                                       overflow,
  input  logic                                       clr_overflow
);

  localparam int PW = ACC_WIDTH + SCALE_WIDTH;
  localparam int RW = PW + 1;
  localparam int DW = TILE_SIZE * OUT_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic signed [RW-1:0] QMAX = RW'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] QMIN = RW'(-(2 ** (OUT_WIDTH - 1)));

  function automatic logic [OUT_WIDTH-1:0] requant(
    input logic signed [PW-1:0]          p,
    input logic        [SHIFT_WIDTH-1:0] sh,
    input logic signed [OUT_WIDTH-1:0]   zp,
    input logic                          relu
  );
    logic signed [RW-1:0] rnd;
    logic signed [RW-1:0] r;
    rnd = (sh != '0) ? (RW'(1) <<< (sh - 1'b1)) : '0;
    r = (RW'(p) + rnd) >>> sh;
    if (relu && r[RW-1]) r = '0;
    r = r + RW'(zp);
    if (r > QMAX)      requant = QMAX[OUT_WIDTH-1:0];
    else if (r < QMIN) requant = QMIN[OUT_WIDTH-1:0];
    else               requant = r[OUT_WIDTH-1:0];
  endfunction

  logic                          s1_vld_q;
  logic signed [PW-1:0]          s1_p_d [TILE_SIZE];
  logic signed [PW-1:0]          s1_p_q [TILE_SIZE];
  logic        [SHIFT_WIDTH-1:0] s1_shift_q;
  logic signed [OUT_WIDTH-1:0]   s1_zp_q;
  logic                          s1_relu_q;
  logic                          s2_vld_q;
  logic        [DW-1:0]          s2_dat_d, s2_dat_q;

  always_comb begin
    for (int k = 0; k < TILE_SIZE; k++) begin
      s1_p_d[k] = $signed(vec_in[k]) * cfg_scale;
    end
  end

  always_comb begin
    s2_dat_d = '0;
    for (int k = 0; k < TILE_SIZE; k++) begin
      s2_dat_d[k*OUT_WIDTH +: OUT_WIDTH] = requant(s1_p_q[k], s1_shift_q, s1_zp_q, s1_relu_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= valid_in;
      s2_vld_q <= s1_vld_q;
    end
  end

  // Config travels with its vector so mid-stream changes only affect later samples.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      s1_p_q     <= s1_p_d;
      s1_shift_q <= cfg_shift;
      s1_zp_q    <= cfg_zero_point;
      s1_relu_q  <= cfg_relu_en;
    end
    if (s1_vld_q) s2_dat_q <= s2_dat_d;
  end

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] count_d, count_q;
  logic          ovf_d, ovf_q;
  logic          full, pop, wr_en, drop;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign pop   = out_valid && out_ready;
  assign wr_en = s2_vld_q && (!full || pop);
  assign drop  = s2_vld_q && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (pop && !wr_en) count_d = count_q - 1'b1;
    if (drop)              ovf_d = 1'b1;
    else if (clr_overflow) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= s2_dat_q;
  end

  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_vec_requant_buffer.sv
// Randomized and directed checks of vec_requant_buffer against a transaction-level model with a scoreboard queue.
module tb_vec_requant_buffer;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      valid_in;
  logic signed [3:0][31:0]   vec_in;
  logic signed [15:0]        cfg_scale;
  logic        [4:0]         cfg_shift;
  logic signed [7:0]         cfg_zero_point;
  logic                      cfg_relu_en;
  logic                      out_valid;
  logic                      out_ready;
  logic        [31:0]        out_data;
  logic        [3:0]         fifo_count;
  logic                      overflow;
  logic                      clr_overflow;

  vec_requant_buffer dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .vec_in(vec_in),
    .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_zero_point(cfg_zero_point),
    .cfg_relu_en(cfg_relu_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .fifo_count(fifo_count), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_lane(input int acc, input int sc, input int sh,
                                          input int zp, input bit relu);
    longint p, r;
    p = longint'(acc) * longint'(sc);
    if (sh > 0) r = (p + (longint'(1) << (sh - 1))) >>> sh;
    else        r = p;
    if (relu && r < 0) r = 0;
    r = r + zp;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  // Scoreboard: words enter after two pipeline edges; the queue mirrors FIFO contents.
  logic [31:0] exp_word;
  logic [31:0] expq[$];
  bit          m_v1, m_v2, m_ovf, mon_en;
  logic [31:0] m_w1, m_w2;

  always @(posedge clk) begin
    bit was_full, pop;
    if (rst) begin
      m_v1 = 0; m_v2 = 0; m_ovf = 0;
      expq.delete();
    end else begin
      was_full = (expq.size() == 8);
      pop = out_ready && (expq.size() > 0);
      if (pop) void'(expq.pop_front());
      if (m_v2 && was_full && !pop) m_ovf = 1;
      else begin
        if (m_v2) expq.push_back(m_w2);
        if (clr_overflow) m_ovf = 0;
      end
      m_v2 = m_v1; m_w2 = m_w1;
      m_v1 = valid_in; m_w1 = exp_word;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_out_valid", out_valid, expq.size() > 0);
      chk("mon_fifo_count", fifo_count, expq.size());
      chk("mon_overflow", overflow, m_ovf);
      if (expq.size() > 0) chk("mon_out_data", out_data, expq[0]);
      else                 chk("mon_out_data_empty", out_data, 0);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cfg(input int sc, input int sh, input int zp, input bit relu);
    cfg_scale = 16'(sc); cfg_shift = 5'(sh); cfg_zero_point = 8'(zp); cfg_relu_en = relu;
  endtask

  task automatic drive(input int l0, input int l1, input int l2, input int l3);
    int l[4];
    l[0] = l0; l[1] = l1; l[2] = l2; l[3] = l3;
    for (int k = 0; k < 4; k++) begin
      vec_in[k] = l[k];
      exp_word[k*8 +: 8] = ref_lane(l[k], int'(cfg_scale), int'(cfg_shift),
                                    int'(cfg_zero_point), cfg_relu_en);
    end
    valid_in = 1'b1;
  endtask

  initial begin
    rst = 1; valid_in = 0; vec_in = '0; out_ready = 0; clr_overflow = 0; exp_word = '0;
    set_cfg(1, 0, 0, 0);
    step(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_data", out_data, 0);
    rst = 0;
    mon_en = 1;
    step(1);

    // Pass-through and latency
    drive(5, -3, 127, -128);
    step(1); valid_in = 0;
    chk("lat_e0", out_valid, 0);
    step(1);
    chk("lat_e1", out_valid, 0);
    step(1);
    chk("lat_e2", out_valid, 1);
    chk("pass_data", out_data, 32'h807FFD05);
    out_ready = 1; step(1); out_ready = 0;

    set_cfg(3, 2, 0, 0);
    drive(1, 2, -2, -1);
    step(1); valid_in = 0; step(2);
    chk("round_data", out_data, 32'hFFFF0201);
    out_ready = 1; step(1); out_ready = 0;

    set_cfg(1, 0, 10, 1);
    drive(200, -50, 100, 0);
    step(1); valid_in = 0; step(2);
    chk("relu_zp_sat_data", out_data, 32'h0A6E0A7F);
    out_ready = 1; step(1); out_ready = 0;
    step(1);

    // Overflow: nine words into eight entries
    set_cfg(1, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      drive(i, 0, 0, 0);
      step(1);
    end
    valid_in = 0;
    step(2);
    chk("ovf_count", fifo_count, 8);
    chk("ovf_flag", overflow, 1);
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_drain_order", out_data[7:0], i);
      step(1);
    end
    chk("ovf_drained", out_valid, 0);
    out_ready = 0;
    clr_overflow = 1; step(1); clr_overflow = 0;
    chk("ovf_cleared", overflow, 0);

    // Full FIFO with simultaneous pop
    for (int i = 1; i <= 8; i++) begin
      drive(i + 16, 0, 0, 0);
      step(1);
    end
    valid_in = 0;
    step(3);
    chk("full_count", fifo_count, 8);
    drive(99, 1, 2, 3);
    step(1); valid_in = 0;
    step(1); out_ready = 1;
    step(1); out_ready = 0;
    chk("full_pop_count", fifo_count, 8);
    chk("full_pop_ovf", overflow, 0);
    chk("full_pop_head", out_data[7:0], 18);
    out_ready = 1; step(10); out_ready = 0;
    chk("full_pop_empty", out_valid, 0);

    // Reset mid-operation
    for (int i = 1; i <= 3; i++) begin
      drive(i + 32, 0, 0, 0);
      step(1);
    end
    valid_in = 0;
    step(3);
    chk("pre_rst_count", fifo_count, 3);
    drive(77, 0, 0, 0);
    step(1); valid_in = 0;
    rst = 1; step(1); rst = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_data", out_data, 0);
    step(5);
    chk("mid_rst_no_ghost", out_valid, 0);

    // Randomized traffic with random backpressure and config
    for (int c = 0; c < 400; c++) begin
      set_cfg(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 31)),
              int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) != 0)
        drive(int'($urandom), int'($urandom) >>> $urandom_range(0, 24),
              int'($urandom_range(0, 2000)) - 1000, int'($urandom));
      else
        valid_in = 0;
      out_ready = ($urandom_range(0, 9) < 6);
      clr_overflow = ($urandom_range(0, 15) == 0);
      step(1);
    end
    valid_in = 0; clr_overflow = 0; out_ready = 1;
    step(15);
    chk("final_empty", out_valid, 0);

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
